conway_controller: RTL and testbench
====================================

Name: conway_controller

Overview:
Sequencer for the Game of Life cell array. Drives the array-wide reset (load initial pattern from state_0) and the array-wide enable (advance one generation). Supports free-run at a programmable rate, pause, single-step, a generation limit and still-life detection. Sits between board-level buttons/switches and the cell array; all outputs fan out to every cell.

Parameters:
TICK_DIV, 1000000, clk cycles between generations in run mode; legal range >= 1
GEN_WIDTH, 16, width of the generation counter and max_gen

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load_req  input  1  one-cycle pulse: reload the array from state_0
run  input  1  level: 1 = free-run, 0 = pause
step_req  input  1  one-cycle pulse: advance one generation while paused
max_gen  input  GEN_WIDTH  stop after this many generations; 0 = unlimited
board_changed  input  1  OR over all cells of (state_d XOR state_q), driven combinationally by the array
cells_rst  output  1  to every cell rst; loads state_0
cells_ena  output  1  to every cell ena; one-cycle pulse per generation
generation  output  GEN_WIDTH  generations advanced since the last load
running  output  1  1 in RUN or FIRE
done  output  1  1 in DONE
stable  output  1  sticky: halted because the board stopped changing

Behaviour:
- One clock; reset is synchronous and active-high. clk and rst as named above.
- States: LOAD, PAUSE, RUN, FIRE, DONE. All outputs are registered or decoded directly from state and registers; no input-to-output combinational path.
- Decode: cells_rst=1 iff LOAD; cells_ena=1 iff FIRE; running=1 iff RUN or FIRE; done=1 iff DONE.
- Reset: state=LOAD, generation=0, tick=0, stable=0. cells_rst is therefore 1 during and for the first cycle after reset. All other outputs are 0.
- Global priority: rst > load_req > everything else. load_req in any state: next state LOAD, generation=0, tick=0, stable=0.
- LOAD: lasts exactly 1 cycle (unless load_req is re-asserted), then PAUSE.
- PAUSE: run=1 -> RUN with tick=0. Otherwise step_req=1 -> FIRE. Otherwise stay.
- RUN:
  - run=0 -> PAUSE with tick=0.
  - tick==TICK_DIV-1 -> FIRE with tick=0.
  - Otherwise tick++.
  - step_req is ignored.
  - Period between cells_ena pulses is TICK_DIV+1 cycles. With TICK_DIV=1, cells_ena is high every other cycle.
- FIRE: lasts exactly 1 cycle. board_changed is sampled in this cycle; it reflects the pre-update board.
  - board_changed=0: stable<=1, generation unchanged, -> DONE. The cell update is harmless because it is a no-op.
  - board_changed=1: generation<=generation+1. Then:
    - new value == max_gen with max_gen!=0 -> DONE;
    - else new value == all-ones -> DONE (saturation; never wraps);
    - else run=1 -> RUN with tick=0;
    - else -> PAUSE.
- DONE: holds. run and step_req are ignored; only load_req or rst exit.
- max_gen changed mid-run: compared only in FIRE. If max_gen is set below the current generation, the controller keeps running until saturation.
- Simultaneous load_req and step_req: load wins; the step is dropped, not queued.
- Reset mid-FIRE: this cycle's cells_ena pulse still reaches the cells. Cell rst overrides ena, so the array reloads regardless.

Test Plan:
- TICK_DIV=4. Release rst -> cells_rst=1 on the first post-reset cycle, then 0. State PAUSE, generation=0, cells_ena=0.
- Blinker loaded, board_changed=1, run=1 for 20 cycles -> cells_ena pulses exactly every 5 cycles, generation 0->4, running=1. Drop run -> PAUSE within 1 cycle, no further pulses.
- Paused, three step_req pulses 3 cycles apart -> exactly three 1-cycle cells_ena pulses, each 1 cycle after its request; generation=3. step_req while in RUN -> no extra pulse.
- max_gen=2, run=1 -> exactly 2 pulses, generation=2, done=1, stable=0. Further run/step are ignored. load_req -> generation=0, done=0, one cells_rst cycle.
- Block pattern (board_changed=0), run=1 -> first FIRE sets stable=1, done=1, generation=0.
- GEN_WIDTH=3, max_gen=0, board_changed=1, run=1 -> halts at generation=7 with done=1, no wrap. load_req and step_req in the same cycle -> LOAD, no cells_ena.

Source files
------------

// File: rtl/conway_controller.sv
// conway_controller: sequences load, free-run, single-step and halt for the Game of Life cell array
module conway_controller #(
  parameter int TICK_DIV  = 1000000,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 run,
  input  logic                 step_req,
  input  logic [GEN_WIDTH-1:0] max_gen,
  input  logic                 board_changed,
  output logic                 cells_rst,
  output logic                 cells_ena,
  output logic [GEN_WIDTH-1:0] generation,
  output logic                 running,
  output logic                 done,
  output logic                 stable
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  typedef enum logic [2:0] {LOAD, PAUSE, RUN, FIRE, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [GEN_WIDTH-1:0] gen_n, gen_inc;
  logic stable_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      tick       <= '0;
      generation <= '0;
      stable     <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      generation <= gen_n;
      stable     <= stable_n;
    end
  end
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    gen_n    = generation;
    stable_n = stable;
    gen_inc  = generation + 1'b1;
    if (load_req) begin
      state_n  = LOAD;
      tick_n   = '0;
      gen_n    = '0;
      stable_n = 1'b0;
    end else begin
      case (state)
        LOAD:  state_n = PAUSE;
        PAUSE: begin
          tick_n  = '0;
          state_n = run ? RUN : step_req ? FIRE : PAUSE;
        end
        RUN: begin
          state_n = !run ? PAUSE : tick == TICK_LAST ? FIRE : RUN;
          tick_n  = (!run || tick == TICK_LAST) ? '0 : tick + 1'b1;
        end
        FIRE: begin
          tick_n = '0;
          // a quiet board means the update was a no-op, so the generation is not counted
          if (!board_changed) begin
            stable_n = 1'b1;
            state_n  = DONE;
          end else begin
            gen_n   = gen_inc;
            state_n = ((max_gen != '0 && gen_inc == max_gen) || &gen_inc) ? DONE :
                      run ? RUN : PAUSE;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = LOAD;
      endcase
    end
  end
  assign cells_rst = state == LOAD;
  assign cells_ena = state == FIRE;
  assign running   = state == RUN || state == FIRE;
  assign done      = state == DONE;
endmodule

// File: tb/tb_conway_controller.sv
// tb_conway_controller: directed scenarios for the Game of Life sequencer
module tb_conway_controller;
  logic clk = 0, rst = 1;
  logic load_req = 0, run = 0, step_req = 0, board_changed = 1;
  logic [15:0] max_gen = '0;
  logic cells_rst, cells_ena, running, done, stable;
  logic [15:0] generation;
  logic load2 = 0, run2 = 0, step2 = 0, board2 = 1;
  logic [2:0] max2 = '0;
  logic rst2_o, ena2_o, running2, done2, stable2;
  logic [2:0] gen2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  conway_controller #(.TICK_DIV(4), .GEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .run(run), .step_req(step_req),
    .max_gen(max_gen), .board_changed(board_changed), .cells_rst(cells_rst),
    .cells_ena(cells_ena), .generation(generation), .running(running),
    .done(done), .stable(stable));

  conway_controller #(.TICK_DIV(1), .GEN_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .load_req(load2), .run(run2), .step_req(step2),
    .max_gen(max2), .board_changed(board2), .cells_rst(rst2_o),
    .cells_ena(ena2_o), .generation(gen2), .running(running2),
    .done(done2), .stable(stable2));

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load();
    load_req = 1;
    cyc();
    load_req = 0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(2);
    checks++; if (cells_rst !== 1'b1) begin errors++; $display("FAIL reset_cells_rst got %b exp 1", cells_rst); end
    checks++; if ({cells_ena, running, done, stable} !== 4'b0) begin errors++; $display("FAIL reset_outs got %b exp 0000", {cells_ena, running, done, stable}); end
    checks++; if (generation !== 16'd0) begin errors++; $display("FAIL reset_gen got %0d exp 0", generation); end
    rst = 0;
    checks++; if (cells_rst !== 1'b1) begin errors++; $display("FAIL post_reset_cells_rst got %b exp 1", cells_rst); end
    cyc();
    checks++; if ({cells_rst, cells_ena, running, done} !== 4'b0) begin errors++; $display("FAIL pause_outs got %b exp 0000", {cells_rst, cells_ena, running, done}); end
  endtask

  task automatic test_run();
    logic [20:0] obs, exp_mask;
    obs = '0;
    exp_mask = '0;
    for (int i = 5; i <= 20; i += 5) exp_mask[i] = 1'b1;
    board_changed = 1;
    run = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      obs[i] = cells_ena;
    end
    checks++; if (obs !== exp_mask) begin errors++; $display("FAIL run_pulses got %h exp %h", obs, exp_mask); end
    cyc();
    checks++; if (generation !== 16'd4) begin errors++; $display("FAIL run_gen got %0d exp 4", generation); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b exp 1", running); end
    run = 0;
    cyc();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b exp 0", running); end
    obs = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      obs[i] = cells_ena;
    end
    checks++; if (obs !== 21'd0 || generation !== 16'd4) begin errors++; $display("FAIL pause_quiet got %h gen %0d exp 0 gen 4", obs, generation); end
  endtask

  task automatic test_step();
    int pulses;
    logic [4:0] obs;
    do_load();
    checks++; if (generation !== 16'd0) begin errors++; $display("FAIL step_load_gen got %0d exp 0", generation); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1;
      cyc();
      step_req = 0;
      checks++; if (cells_ena !== 1'b1) begin errors++; $display("FAIL step_pulse%0d got %b exp 1", k, cells_ena); end
      pulses += int'(cells_ena);
      cyc();
      pulses += int'(cells_ena);
      cyc();
      pulses += int'(cells_ena);
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL step_count got %0d exp 3", pulses); end
    checks++; if (generation !== 16'd3) begin errors++; $display("FAIL step_gen got %0d exp 3", generation); end
    run = 1;
    obs = '0;
    for (int i = 0; i < 5; i++) begin
      step_req = (i == 1);
      cyc();
      obs[i] = cells_ena;
    end
    step_req = 0;
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL step_in_run got %b exp 10000", obs); end
    run = 0;
    cyc();
    checks++; if (generation !== 16'd4 || running !== 1'b0) begin errors++; $display("FAIL step_in_run_gen got %0d run %b exp 4 0", generation, running); end
  endtask

  task automatic test_max_gen();
    int pulses, rsts;
    do_load();
    max_gen = 16'd2;
    run = 1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      pulses += int'(cells_ena);
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL max_pulses got %0d exp 2", pulses); end
    checks++; if (generation !== 16'd2) begin errors++; $display("FAIL max_gen got %0d exp 2", generation); end
    checks++; if ({done, stable, running} !== 3'b100) begin errors++; $display("FAIL max_flags got %b exp 100", {done, stable, running}); end
    step_req = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      pulses += int'(cells_ena);
    end
    step_req = 0;
    checks++; if (pulses !== 0 || done !== 1'b1) begin errors++; $display("FAIL done_hold got pulses %0d done %b exp 0 1", pulses, done); end
    run = 0;
    max_gen = '0;
    load_req = 1;
    cyc();
    load_req = 0;
    checks++; if ({cells_rst, done} !== 2'b10 || generation !== 16'd0) begin errors++; $display("FAIL reload got rst/done %b gen %0d exp 10 0", {cells_rst, done}, generation); end
    rsts = int'(cells_rst);
    for (int i = 0; i < 4; i++) begin
      cyc();
      rsts += int'(cells_rst);
    end
    checks++; if (rsts !== 1) begin errors++; $display("FAIL reload_rst_cycles got %0d exp 1", rsts); end
  endtask

  task automatic test_still();
    int pulses;
    board_changed = 0;
    run = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      pulses += int'(cells_ena);
    end
    checks++; if ({done, stable} !== 2'b11) begin errors++; $display("FAIL still_flags got %b exp 11", {done, stable}); end
    checks++; if (generation !== 16'd0 || pulses !== 1) begin errors++; $display("FAIL still_gen got %0d pulses %0d exp 0 1", generation, pulses); end
    run = 0;
    board_changed = 1;
    load_req = 1;
    cyc();
    load_req = 0;
    checks++; if ({stable, done} !== 2'b00) begin errors++; $display("FAIL still_clear got %b exp 00", {stable, done}); end
    cyc();
  endtask

  task automatic test_saturate();
    logic [13:0] obs;
    int pulses;
    board2 = 1;
    max2 = '0;
    run2 = 1;
    obs = '0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i < 14) obs[i] = ena2_o;
      pulses += int'(ena2_o);
    end
    checks++; if (obs !== 14'h2AAA) begin errors++; $display("FAIL div1_pattern got %h exp 2aaa", obs); end
    checks++; if (pulses !== 7) begin errors++; $display("FAIL sat_pulses got %0d exp 7", pulses); end
    checks++; if (gen2 !== 3'd7 || done2 !== 1'b1) begin errors++; $display("FAIL sat_halt got gen %0d done %b exp 7 1", gen2, done2); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    run2 = 0;
    load2 = 1;
    step2 = 1;
    cyc();
    load2 = 0;
    step2 = 0;
    checks++; if ({rst2_o, ena2_o, done2} !== 3'b100) begin errors++; $display("FAIL load_step got %b exp 100", {rst2_o, ena2_o, done2}); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pulses += int'(ena2_o);
    end
    checks++; if (pulses !== 0 || gen2 !== 3'd0) begin errors++; $display("FAIL step_dropped got pulses %0d gen %0d exp 0 0", pulses, gen2); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_max_gen();
    test_still();
    test_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
